seg_scan: RTL

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_pkg.sv | 11 +
 rtl/seg_glyph.sv | 9 +
 rtl/seg_scan.sv | 93 +++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared segment width and hex glyph table for the scanned display
package seg_pkg;
  localparam int SEG_W = 7;
  // Packed so GLYPH[n] is the s[6:0] pattern for hex digit n
  localparam logic [15:0][SEG_W-1:0] GLYPH = {
    7'b1101100, 7'b1101101, 7'b0011111, 7'b1100101,
    7'b0101111, 7'b1111110, 7'b1111011, 7'b1111111,
    7'b1010010, 7'b1101111, 7'b1101011, 7'b0111010,
    7'b1011011, 7'b1011101, 7'b0010010, 7'b1110111
  };
endpackage

// File: rtl/seg_glyph.sv
// seg_glyph: combinational nibble-to-segment decoder
module seg_glyph
  import seg_pkg::*;
(
  input  logic [3:0]       nib,
  output logic [SEG_W-1:0] seg
);
  assign seg = GLYPH[nib];
endmodule

// File: rtl/seg_scan.sv
// seg_scan: multiplexed hex display scanner with frame-aligned loading,
// leading-zero blanking and per-digit blink
module seg_scan
  import seg_pkg::*;
#(
  parameter int NDIG         = 4,
  parameter int DIV          = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              load,
  input  logic              blank_lz,
  input  logic [NDIG-1:0]   blink_en,
  output logic [SEG_W-1:0]  seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              frame
);
  localparam int DW = $clog2(DIV);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [DW-1:0]      div_cnt;
  logic [IW-1:0]      idx;
  logic [BW-1:0]      blink_cnt;
  logic               blink_ph, pend_v, last_div, last_blink, dark;
  logic [4*NDIG-1:0]  pend_val, act_val;
  logic [NDIG-1:0]    pend_dp, act_dp, lz;
  logic [3:0]         nib;
  logic [SEG_W-1:0]   glyph;
  assign last_div   = div_cnt == DW'(DIV - 1);
  assign frame      = last_div && idx == IW'(NDIG - 1);
  assign last_blink = blink_cnt == BW'(BLINK_FRAMES - 1);
  assign nib        = act_val[4*idx +: 4];
  assign dark       = blink_ph && blink_en[idx];
  seg_glyph u_glyph (.nib(nib), .seg(glyph));
  // Digit k is a leading zero when it and every higher nibble are zero
  always_comb begin
    lz = '0;
    for (int k = 1; k < NDIG; k++) lz[k] = blank_lz && (act_val >> (4*k)) == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      div_cnt <= last_div ? '0 : div_cnt + 1'b1;
      if (last_div) idx <= idx == IW'(NDIG - 1) ? '0 : idx + 1'b1;
    end
  end
  // Active only moves at the frame boundary; a coincident load wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
      pend_v   <= 1'b0;
      act_val  <= '0;
      act_dp   <= '0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
      pend_v <= frame ? 1'b0 : (pend_v || load);
      if (frame && (pend_v || load)) begin
        act_val <= load ? value : pend_val;
        act_dp  <= load ? dp_in : pend_dp;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (frame) begin
      blink_cnt <= last_blink ? '0 : blink_cnt + 1'b1;
      if (last_blink) blink_ph <= ~blink_ph;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= '0;
      dp  <= 1'b0;
      an  <= '0;
    end else begin
      seg <= (lz[idx] || dark) ? '0 : glyph;
      dp  <= act_dp[idx] && !dark;
      an  <= NDIG'(1) << idx;
    end
  end
endmodule
